// File: rtl/ofifo_drain_pkg.sv
// ofifo_drain_pkg: shared FSM type, default geometry and credit sizing
// for the output-FIFO drain controller.
package ofifo_drain_pkg;

  localparam int COL    = 8;
  localparam int BW     = 16;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One extra bit so the counter can hold the full depth value.
  function automatic int credit_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/ofifo_drain_credit.sv
// ofifo_drain_credit: up/down row-credit counter that saturates at depth
// and raises a sticky overflow flag.
module ofifo_drain_credit
  import ofifo_drain_pkg::*;
#(
  parameter int depth = DEPTH,
  parameter int cw    = credit_w(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [cw-1:0] credit,
  output logic          err
);

  localparam logic [cw-1:0] FULL = cw'(depth);

  logic ovf;
  logic up;
  logic dn;

  assign ovf = inc && !dec && (credit == FULL);
  assign up  = inc && !dec && !ovf;
  assign dn  = dec && !inc && (credit != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit <= '0;
      err    <= 1'b0;
    end else begin
      unique case (1'b1)
        up:      credit <= credit + cw'(1);
        dn:      credit <= credit - cw'(1);
        default: ;
      endcase
      // A new overflow outranks a clear arriving in the same cycle.
      if (ovf)
        err <= 1'b1;
      else if (clr)
        err <= 1'b0;
    end
  end

endmodule

// File: rtl/ofifo_drain.sv
// ofifo_drain: pops complete rows from the output FIFO bank into psum SRAM.
// Build option OFIFO_DRAIN_RELU_EN clamps negative lanes to zero on capture.
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col    = COL,
  parameter int bw     = BW,
  parameter int addr_w = ADDR_W,
  parameter int depth  = DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [addr_w-1:0] num_rows,
  input  logic              fifo_valid,
  input  logic [col*bw-1:0] fifo_out,
  output logic              fifo_rd,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [addr_w-1:0] mem_a,
  output logic [col*bw-1:0] mem_d,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int cw = credit_w(depth);

  state_e            state;
  state_e            state_nxt;
  logic [cw-1:0]     credit;
  logic [addr_w-1:0] rows_q;
  logic [addr_w-1:0] cnt_q;
  logic [addr_w-1:0] addr_q;
  logic [col*bw-1:0] cap_d;
  logic              accept;
  logic              pop;
  logic              last;

  assign accept  = start && (state == IDLE);
  // Pops look only at registered credit, never at this cycle's fifo_valid.
  assign pop     = (state == RUN) && (credit != '0)
                && (cnt_q < rows_q);
  assign last    = pop && (cnt_q == rows_q - addr_w'(1));
  assign fifo_rd = pop;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  ofifo_drain_credit #(
    .depth (depth),
    .cw    (cw)
  ) u_credit (
    .clk    (clk),
    .reset  (reset),
    .inc    (fifo_valid),
    .dec    (pop),
    .clr    (accept),
    .credit (credit),
    .err    (err)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)
                 state_nxt = (num_rows == '0) ? DONE : RUN;
      RUN:     if (last) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_d = fifo_out;
`ifdef OFIFO_DRAIN_RELU_EN
    for (int i = 0; i < col; i++) begin
      if (fifo_out[i*bw+bw-1])
        cap_d[i*bw +: bw] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rows_q <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rows_q <= num_rows;
        cnt_q  <= '0;
        addr_q <= base_addr;
      end else if (pop) begin
        cnt_q  <= cnt_q + addr_w'(1);
        addr_q <= addr_q + addr_w'(1);
      end
    end
  end

  // Capture on pop; the SRAM write follows one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_cen <= 1'b1;
      mem_wen <= 1'b1;
      mem_a   <= '0;
      mem_d   <= '0;
    end else begin
      mem_cen <= !pop;
      mem_wen <= !pop;
      if (pop) begin
        mem_a <= addr_q;
        mem_d <= cap_d;
      end
    end
  end

endmodule

// File: tb/tb_ofifo_drain.sv
// tb_ofifo_drain: scoreboard bench for the output-FIFO drain controller.
// Mirrors OFIFO_DRAIN_RELU_EN in its expected-data model.
module tb_ofifo_drain;

  localparam int AW = 11;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_rows = '0;
  logic          fifo_valid = 1'b0;
  logic [DW-1:0] fifo_out = '0;
  logic          fifo_rd;
  logic          mem_cen;
  logic          mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          busy;
  logic          done;
  logic          err;

  ofifo_drain #(
    .col    (8),
    .bw     (16),
    .addr_w (AW),
    .depth  (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .fifo_valid (fifo_valid),
    .fifo_out   (fifo_out),
    .fifo_rd    (fifo_rd),
    .mem_cen    (mem_cen),
    .mem_wen    (mem_wen),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    longint        t;
  } wr_t;

  int            n_chk = 0;
  int            n_fail = 0;
  longint        cyc = 0;
  int            pops_req = 0;
  int            pops_done = 0;
  wr_t           wr_q[$];
  longint        rd_t[$];
  longint        done_t[$];
  longint        vt[$];
  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] dq[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (!mem_cen && !mem_wen)
      wr_q.push_back('{mem_a, mem_d, cyc});
    if (fifo_rd) begin
      rd_t.push_back(cyc);
      pops_req = pops_req + 1;
    end
    if (done)
      done_t.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required test end");
    $fatal(1);
  end

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef OFIFO_DRAIN_RELU_EN
    for (int i = 0; i < 8; i++)
      if (d[i*16+15]) r[i*16 +: 16] = '0;
`endif
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_row();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Advance one cycle; retire popped rows from the FIFO model.
  task automatic tick();
    @(posedge clk);
    #1;
    while (pops_done < pops_req) begin
      if (fq.size() != 0) void'(fq.pop_front());
      pops_done++;
    end
    fifo_out = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_row(input logic [DW-1:0] d);
    fifo_valid = 1'b1;
    fq.push_back(d);
    dq.push_back(d);
    vt.push_back(cyc);
    tick();
    fifo_valid = 1'b0;
  endtask

  task automatic start_job(input logic [AW-1:0] b,
                           input logic [AW-1:0] n,
                           output longint c);
    start = 1'b1;
    base_addr = b;
    num_rows = n;
    c = cyc;
    for (int i = 0; i < int'(n); i++)
      exp_a.push_back(b + AW'(i));
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    fifo_valid = 1'b0;
    tick();
    tick();
    fq.delete();
    dq.delete();
    exp_a.delete();
    pops_done = pops_req;
    fifo_out = '0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({fifo_rd, mem_cen, mem_wen, busy, done, err} !== 6'b011000) begin
      n_fail++;
      $display("FAIL reset_ctl: rd/cen/wen/busy/done/err=%b, required 011000",
               {fifo_rd, mem_cen, mem_wen, busy, done, err});
    end
    n_chk++;
    if (mem_a !== '0 || mem_d !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: a=%h d=%h, required 0", mem_a, mem_d);
    end
    n_chk++;
    if (dut.credit !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_credit: got %0d, required 0", dut.credit);
    end
    reset = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({fifo_rd, mem_cen, mem_wen, busy, done} !== 5'b01100) begin
      n_fail++;
      $display("FAIL idle_ctl: got %b, required 01100",
               {fifo_rd, mem_cen, mem_wen, busy, done});
    end
  endtask

  task automatic test_basic();
    int w0, r0, d0;
    longint c;
    logic [DW-1:0] d, ed;
    logic [AW-1:0] ea;
    logic [31:0] lanes;
    wr_t w;
    do_reset();
    w0 = wr_q.size(); r0 = rd_t.size(); d0 = done_t.size();
    for (int i = 0; i < 4; i++) begin
      d = rnd_row();
      if (i == 0) d[31:0] = 32'h0005_FFF0;
      push_row(d);
    end
    start_job(11'h010, 11'd4, c);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b, required 1", busy);
    end
    for (int i = 0; i < 40 && done_t.size() == d0; i++) tick();
    n_chk++;
    if (done_t.size() != d0 + 1) begin
      n_fail++;
      $display("FAIL basic_done: %0d pulses, required 1", done_t.size() - d0);
    end else begin
      n_chk++;
      if (done_t[d0] !== c + 6) begin
        n_fail++;
        $display("FAIL basic_done_t: cycle %0d, required %0d", done_t[d0], c + 6);
      end
    end
    n_chk++;
    if (rd_t.size() - r0 != 4) begin
      n_fail++;
      $display("FAIL basic_rd_n: %0d pops, required 4", rd_t.size() - r0);
    end
    for (int i = 0; i < 4 && r0 + i < rd_t.size(); i++) begin
      n_chk++;
      if (rd_t[r0+i] !== c + 1 + i) begin
        n_fail++;
        $display("FAIL basic_rd%0d: cycle %0d, required %0d", i, rd_t[r0+i], c + 1 + i);
      end
    end
    n_chk++;
    if (wr_q.size() - w0 != 4) begin
      n_fail++;
      $display("FAIL basic_wr_n: %0d writes, required 4", wr_q.size() - w0);
    end
    for (int k = 0; w0 + k < wr_q.size(); k++) begin
      w = wr_q[w0+k];
      ea = exp_a.pop_front();
      ed = relu(dq.pop_front());
      n_chk++;
      if (w.a !== ea || w.d !== ed || w.t !== c + 2 + k) begin
        n_fail++;
        $display("FAIL basic_wr%0d: a=%h d=%h t=%0d, required a=%h d=%h t=%0d",
                 k, w.a, w.d, w.t, ea, ed, c + 2 + k);
      end
    end
`ifdef OFIFO_DRAIN_RELU_EN
    lanes = 32'h0005_0000;
`else
    lanes = 32'h0005_FFF0;
`endif
    if (wr_q.size() > w0) begin
      n_chk++;
      if (wr_q[w0].d[31:0] !== lanes) begin
        n_fail++;
        $display("FAIL lane_clamp: got %h, required %h", wr_q[w0].d[31:0], lanes);
      end
    end
  endtask

  task automatic test_starved();
    int w0, r0, d0, v0;
    longint c;
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    wr_t w;
    do_reset();
    w0 = wr_q.size(); r0 = rd_t.size(); d0 = done_t.size(); v0 = vt.size();
    start_job(11'h100, 11'd3, c);
    for (int i = 0; i < 3; i++) begin
      push_row(rnd_row());
      repeat (4) tick();
    end
    for (int i = 0; i < 40 && done_t.size() == d0; i++) tick();
    n_chk++;
    if (rd_t.size() - r0 != 3 || done_t.size() != d0 + 1) begin
      n_fail++;
      $display("FAIL starve_count: pops=%0d done=%0d, required 3 and 1",
               rd_t.size() - r0, done_t.size() - d0);
    end
    for (int i = 0; i < 3 && r0 + i < rd_t.size(); i++) begin
      n_chk++;
      if (rd_t[r0+i] !== vt[v0+i] + 1) begin
        n_fail++;
        $display("FAIL starve_rd%0d: cycle %0d, required %0d", i, rd_t[r0+i], vt[v0+i] + 1);
      end
    end
    n_chk++;
    if (wr_q.size() - w0 != 3) begin
      n_fail++;
      $display("FAIL starve_wr_n: %0d writes, required 3", wr_q.size() - w0);
    end
    for (int k = 0; w0 + k < wr_q.size() && r0 + k < rd_t.size(); k++) begin
      w = wr_q[w0+k];
      ea = exp_a.pop_front();
      ed = relu(dq.pop_front());
      n_chk++;
      if (w.a !== ea || w.d !== ed || w.t !== rd_t[r0+k] + 1) begin
        n_fail++;
        $display("FAIL starve_wr%0d: a=%h d=%h t=%0d, required a=%h d=%h t=%0d",
                 k, w.a, w.d, w.t, ea, ed, rd_t[r0+k] + 1);
      end
    end
  endtask

  task automatic test_simultaneous();
    int w0, r0, d0;
    longint c;
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    wr_t w;
    do_reset();
    w0 = wr_q.size(); r0 = rd_t.size(); d0 = done_t.size();
    push_row(rnd_row());
    start_job(11'h200, 11'd2, c);
    push_row(rnd_row());
    n_chk++;
    if (dut.credit !== 7'd1) begin
      n_fail++;
      $display("FAIL simul_credit: got %0d, required 1", dut.credit);
    end
    n_chk++;
    if (rd_t.size() <= r0 || rd_t[r0] !== c + 1) begin
      n_fail++;
      $display("FAIL simul_rd: first pop missing or late, required cycle %0d", c + 1);
    end
    for (int i = 0; i < 40 && done_t.size() == d0; i++) tick();
    n_chk++;
    if (wr_q.size() - w0 != 2 || dut.credit !== 7'd0) begin
      n_fail++;
      $display("FAIL simul_end: writes=%0d credit=%0d, required 2 and 0",
               wr_q.size() - w0, dut.credit);
    end
    for (int k = 0; w0 + k < wr_q.size(); k++) begin
      w = wr_q[w0+k];
      ea = exp_a.pop_front();
      ed = relu(dq.pop_front());
      n_chk++;
      if (w.a !== ea || w.d !== ed) begin
        n_fail++;
        $display("FAIL simul_wr%0d: a=%h d=%h, required a=%h d=%h", k, w.a, w.d, ea, ed);
      end
    end
  endtask

  task automatic test_overflow_wrap();
    int w0, d0;
    longint c;
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    wr_t w;
    do_reset();
    for (int i = 0; i < 65; i++) begin
      push_row(rnd_row());
      if (i == 63) begin
        n_chk++;
        if (err !== 1'b0 || dut.credit !== 7'd64) begin
          n_fail++;
          $display("FAIL ovf_full: err=%b credit=%0d, required 0 and 64", err, dut.credit);
        end
      end
    end
    n_chk++;
    if (err !== 1'b1 || dut.credit !== 7'd64) begin
      n_fail++;
      $display("FAIL ovf_err: err=%b credit=%0d, required 1 and 64", err, dut.credit);
    end
    w0 = wr_q.size(); d0 = done_t.size();
    start_job(11'h123, 11'd0, c);
    n_chk++;
    if (err !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_job: err=%b done=%b busy=%b, required 0 1 1", err, done, busy);
    end
    repeat (4) tick();
    n_chk++;
    if (wr_q.size() != w0 || done_t.size() != d0 + 1 || busy !== 1'b0
        || dut.credit !== 7'd64) begin
      n_fail++;
      $display("FAIL zero_end: writes=%0d done=%0d busy=%b credit=%0d, required 0 1 0 64",
               wr_q.size() - w0, done_t.size() - d0, busy, dut.credit);
    end
    do_reset();
    w0 = wr_q.size(); d0 = done_t.size();
    for (int i = 0; i < 3; i++) push_row(rnd_row());
    start_job(11'h7FE, 11'd3, c);
    for (int i = 0; i < 40 && done_t.size() == d0; i++) tick();
    n_chk++;
    if (wr_q.size() - w0 != 3) begin
      n_fail++;
      $display("FAIL wrap_n: %0d writes, required 3", wr_q.size() - w0);
    end else begin
      n_chk++;
      if (wr_q[w0+2].a !== 11'h000) begin
        n_fail++;
        $display("FAIL wrap_addr: got %h, required 000", wr_q[w0+2].a);
      end
    end
    for (int k = 0; w0 + k < wr_q.size(); k++) begin
      w = wr_q[w0+k];
      ea = exp_a.pop_front();
      ed = relu(dq.pop_front());
      n_chk++;
      if (w.a !== ea || w.d !== ed) begin
        n_fail++;
        $display("FAIL wrap_wr%0d: a=%h d=%h, required a=%h d=%h", k, w.a, w.d, ea, ed);
      end
    end
  endtask

  task automatic test_busy_start();
    int w0, r0, d0;
    longint c;
    wr_t w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    do_reset();
    w0 = wr_q.size(); r0 = rd_t.size(); d0 = done_t.size();
    push_row(rnd_row());
    push_row(rnd_row());
    start_job(11'h300, 11'd2, c);
    start = 1'b1;
    base_addr = 11'h555;
    num_rows = 11'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && done_t.size() == d0; i++) tick();
    push_row(rnd_row());
    repeat (6) tick();
    n_chk++;
    if (rd_t.size() - r0 != 2 || wr_q.size() - w0 != 2 || done_t.size() != d0 + 1) begin
      n_fail++;
      $display("FAIL busy_start: pops=%0d writes=%0d done=%0d, required 2 2 1",
               rd_t.size() - r0, wr_q.size() - w0, done_t.size() - d0);
    end
    for (int k = 0; k < 2 && w0 + k < wr_q.size(); k++) begin
      w = wr_q[w0+k];
      ea = exp_a.pop_front();
      ed = relu(dq.pop_front());
      n_chk++;
      if (w.a !== ea || w.d !== ed) begin
        n_fail++;
        $display("FAIL busy_wr%0d: a=%h d=%h, required a=%h d=%h", k, w.a, w.d, ea, ed);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    longint c;
    do_reset();
    for (int i = 0; i < 5; i++) push_row(rnd_row());
    start_job(11'h400, 11'd5, c);
    tick();
    tick();
    n_chk++;
    if (fifo_rd !== 1'b1 || mem_cen !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_active: rd=%b cen=%b busy=%b, required 1 0 1", fifo_rd, mem_cen, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({fifo_rd, mem_cen, mem_wen, busy, done, err} !== 6'b011000
        || mem_a !== '0 || mem_d !== '0 || dut.credit !== 7'd0) begin
      n_fail++;
      $display("FAIL mid_reset: ctl=%b a=%h credit=%0d, required 011000 000 0",
               {fifo_rd, mem_cen, mem_wen, busy, done, err}, mem_a, dut.credit);
    end
    tick();
    fq.delete();
    dq.delete();
    exp_a.delete();
    pops_done = pops_req;
    fifo_out = '0;
    reset = 1'b1;
    w0 = wr_q.size(); d0 = done_t.size();
    repeat (8) tick();
    n_chk++;
    if (done_t.size() != d0 || wr_q.size() != w0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: done=%0d writes=%0d busy=%b, required 0 0 0",
               done_t.size() - d0, wr_q.size() - w0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starved();
    test_simultaneous();
    test_overflow_wrap();
    test_busy_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
